dit_butterfly: RTL and testbench

DIT_BUTTERFLY -- requirements
Module: dit_butterfly

---
 rtl/fft_pkg.sv | 14 +
 rtl/cmult_tw.sv | 76 +++++++
 rtl/dit_butterfly.sv | 189 ++++++++++++++++++
 tb/tb_dit_butterfly.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the radix-2 FFT datapath: Q2.12 twiddle format and
// the serializer state encoding.
package fft_pkg;

  localparam int TW_W     = 14;
  localparam int TW_FRAC  = 12;
  localparam int TW_ROUND = 2048;

  typedef enum logic {
    IDLE   = 1'b0,
    EMIT_Y = 1'b1
  } ser_state_t;

endpackage

// File: rtl/cmult_tw.sv
// Two-stage complex multiply B * (cos - j*sin) with round-half-up back to
// sample scale; A and valid ride alongside so they stay aligned with BW.
module cmult_tw
  import fft_pkg::*;
#(
  parameter int bit_width = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [bit_width-1:0] a_re,
  input  logic signed [bit_width-1:0] a_im,
  input  logic signed [bit_width-1:0] b_re,
  input  logic signed [bit_width-1:0] b_im,
  input  logic signed [TW_W-1:0]      cos_data,
  input  logic signed [TW_W-1:0]      sin_data,
  output logic                        out_valid,
  output logic signed [bit_width-1:0] a_re_d,
  output logic signed [bit_width-1:0] a_im_d,
  output logic signed [bit_width+1:0] bw_re,
  output logic signed [bit_width+1:0] bw_im
);

  localparam int PW   = bit_width + TW_W;
  localparam int SW   = PW + 2;
  localparam int BW_W = bit_width + 2;

  logic signed [PW-1:0]        rc_p1, is_p1, ic_p1, rs_p1;
  logic signed [bit_width-1:0] a_re_p1, a_im_p1;
  logic                        vld_p1;

  logic signed [SW-1:0]        sum_re, sum_im;
  logic signed [BW_W-1:0]      bw_re_p2, bw_im_p2;
  logic signed [bit_width-1:0] a_re_p2, a_im_p2;
  logic                        vld_p2;

  // Stage 1: four full-precision partial products
  always_ff @(posedge clk) begin
    rc_p1   <= PW'(b_re) * PW'(cos_data);
    is_p1   <= PW'(b_im) * PW'(sin_data);
    ic_p1   <= PW'(b_im) * PW'(cos_data);
    rs_p1   <= PW'(b_re) * PW'(sin_data);
    a_re_p1 <= a_re;
    a_im_p1 <= a_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= in_valid;
  end

  // Stage 2: combine products, round half up, drop the Q12 fraction
  always_comb begin
    sum_re = SW'(rc_p1) + SW'(is_p1) + SW'(TW_ROUND);
    sum_im = SW'(ic_p1) - SW'(rs_p1) + SW'(TW_ROUND);
  end

  always_ff @(posedge clk) begin
    bw_re_p2 <= BW_W'(sum_re >>> TW_FRAC);
    bw_im_p2 <= BW_W'(sum_im >>> TW_FRAC);
    a_re_p2  <= a_re_p1;
    a_im_p2  <= a_im_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  assign out_valid = vld_p2;
  assign a_re_d    = a_re_p2;
  assign a_im_d    = a_im_p2;
  assign bw_re     = bw_re_p2;
  assign bw_im     = bw_im_p2;

endmodule

// File: rtl/dit_butterfly.sv
// Radix-2 decimation-in-time butterfly: X = A + B*W, Y = A - B*W, emitted
// serially (X then Y) on one output port with optional divide-by-2 scaling.
module dit_butterfly
  import fft_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int SCALE     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [bit_width-1:0] Re_a,
  input  logic signed [bit_width-1:0] Im_a,
  input  logic signed [bit_width-1:0] Re_b,
  input  logic signed [bit_width-1:0] Im_b,
  input  logic signed [TW_W-1:0]      cos_data,
  input  logic signed [TW_W-1:0]      sin_data,
  input  logic                        in_valid,
  output logic signed [bit_width-1:0] out_re,
  output logic signed [bit_width-1:0] out_im,
  output logic                        out_valid,
  output logic                        out_first,
  output logic                        overrun
);

  localparam int W3 = bit_width + 3;
  localparam int W4 = bit_width + 4;
  localparam logic signed [W4-1:0] SAT_MAX = W4'((1 << (bit_width - 1)) - 1);
  localparam logic signed [W4-1:0] SAT_MIN = -SAT_MAX - W4'(1);

  function automatic logic signed [bit_width-1:0] sat(input logic signed [W4-1:0] v);
    if (v > SAT_MAX)      return bit_width'(SAT_MAX);
    else if (v < SAT_MIN) return bit_width'(SAT_MIN);
    else                  return bit_width'(v);
  endfunction

  // Optional halving rounds half up before clamping to the port width.
  function automatic logic signed [bit_width-1:0] shape(input logic signed [W3-1:0] v);
    logic signed [W4-1:0] ve;
    ve = W4'(v);
    if (SCALE != 0) ve = (ve + W4'(1)) >>> 1;
    return sat(ve);
  endfunction

  logic                        guard, accept;
  logic signed [bit_width-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
  logic signed [TW_W-1:0]      cos_p0, sin_p0;
  logic                        vld_p0;

  logic                        vld_p2;
  logic signed [bit_width-1:0] a_re_p2, a_im_p2;
  logic signed [bit_width+1:0] bw_re_p2, bw_im_p2;

  logic signed [W3-1:0]        x_re, x_im, y_re, y_im;
  logic signed [bit_width-1:0] x_re_p3, x_im_p3, y_re_p3, y_im_p3;
  logic                        vld_p3;

  ser_state_t                  state, state_nxt;
  logic signed [bit_width-1:0] y_re_hold, y_im_hold;
  logic signed [bit_width-1:0] out_re_nxt, out_im_nxt;
  logic                        out_valid_nxt, out_first_nxt, load_y;

  // A pair is refused in the cycle right after an accepted one; the refusal is remembered.
  assign accept = in_valid & ~guard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard   <= 1'b0;
      overrun <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      guard   <= accept;
      overrun <= overrun | (in_valid & guard);
      vld_p0  <= accept;
    end
  end

  // Stage 0: capture accepted inputs
  always_ff @(posedge clk) begin
    if (accept) begin
      a_re_p0 <= Re_a;
      a_im_p0 <= Im_a;
      b_re_p0 <= Re_b;
      b_im_p0 <= Im_b;
      cos_p0  <= cos_data;
      sin_p0  <= sin_data;
    end
  end

  cmult_tw #(
    .bit_width(bit_width)
  ) u_cmult (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (vld_p0),
    .a_re     (a_re_p0),
    .a_im     (a_im_p0),
    .b_re     (b_re_p0),
    .b_im     (b_im_p0),
    .cos_data (cos_p0),
    .sin_data (sin_p0),
    .out_valid(vld_p2),
    .a_re_d   (a_re_p2),
    .a_im_d   (a_im_p2),
    .bw_re    (bw_re_p2),
    .bw_im    (bw_im_p2)
  );

  // Stage 3: sum/difference legs at full width, then scale or saturate
  always_comb begin
    x_re = W3'(a_re_p2) + W3'(bw_re_p2);
    x_im = W3'(a_im_p2) + W3'(bw_im_p2);
    y_re = W3'(a_re_p2) - W3'(bw_re_p2);
    y_im = W3'(a_im_p2) - W3'(bw_im_p2);
  end

  always_ff @(posedge clk) begin
    x_re_p3 <= shape(x_re);
    x_im_p3 <= shape(x_im);
    y_re_p3 <= shape(y_re);
    y_im_p3 <= shape(y_im);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p3 <= 1'b0;
    else        vld_p3 <= vld_p2;
  end

  // Serializer: X goes out immediately, Y follows from the hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vld_p3) state_nxt = EMIT_Y;
      EMIT_Y:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_re_nxt    = out_re;
    out_im_nxt    = out_im;
    out_valid_nxt = 1'b0;
    out_first_nxt = 1'b0;
    load_y        = 1'b0;
    case (state)
      IDLE: begin
        if (vld_p3) begin
          out_re_nxt    = x_re_p3;
          out_im_nxt    = x_im_p3;
          out_valid_nxt = 1'b1;
          out_first_nxt = 1'b1;
          load_y        = 1'b1;
        end
      end
      EMIT_Y: begin
        out_re_nxt    = y_re_hold;
        out_im_nxt    = y_im_hold;
        out_valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_y) begin
      y_re_hold <= y_re_p3;
      y_im_hold <= y_im_p3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_re    <= '0;
      out_im    <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
    end else begin
      out_re    <= out_re_nxt;
      out_im    <= out_im_nxt;
      out_valid <= out_valid_nxt;
      out_first <= out_first_nxt;
    end
  end

endmodule

// File: tb/tb_dit_butterfly.sv
// Scoreboard bench: two butterflies (saturating and halving) share stimulus;
// expected X/Y with arrival cycle are queued at issue and popped by monitors.
module tb_dit_butterfly;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic signed [13:0] cos_d = '0, sin_d = '0;
  logic in_valid = 1'b0;

  logic signed [15:0] o_re0, o_im0, o_re1, o_im1;
  logic o_valid0, o_first0, ovr0, o_valid1, o_first1, ovr1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int run0 = 0, run1 = 0, max_run0 = 0, max_run1 = 0;

  typedef struct {
    int   cyc;
    logic first;
    int   re;
    int   im;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // ar, ai, br, bi, cos, sin, | SCALE=0: Xr Xi Yr Yi | SCALE=1: Xr Xi Yr Yi
  localparam int VT[7][14] = '{
    '{   100,    0,  50,  0, 4096,    0,   150,    0,   50,    0,    75,    0,    25,    0},
    '{     0,    0,  50, 20,    0, 4096,    20,  -50,  -20,   50,    10,  -25,   -10,   25},
    '{ 32767,    0,   1,  0, 4096,    0, 32767,    0,32766,    0, 16384,    0, 16383,    0},
    '{   101, -101,   0,  0, 4096,    0,   101, -101,  101, -101,    51,  -50,    51,  -50},
    '{-32768,-32768, -1, -1, 4096,    0,-32768,-32768,-32767,-32767,-16384,-16384,-16383,-16383},
    '{     0,    0,   3, -3, 2048,    0,     2,   -1,   -2,    1,     1,    0,    -1,    1},
    '{  1000, -500, 100,200, 2896, 2896,  1212, -429,  788, -571,   606, -214,   394, -285}
  };

  dit_butterfly #(.bit_width(16), .SCALE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .Re_a(a_re), .Im_a(a_im), .Re_b(b_re), .Im_b(b_im),
    .cos_data(cos_d), .sin_data(sin_d), .in_valid(in_valid),
    .out_re(o_re0), .out_im(o_im0), .out_valid(o_valid0), .out_first(o_first0), .overrun(ovr0)
  );

  dit_butterfly #(.bit_width(16), .SCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Re_a(a_re), .Im_a(a_im), .Re_b(b_re), .Im_b(b_im),
    .cos_data(cos_d), .sin_data(sin_d), .in_valid(in_valid),
    .out_re(o_re1), .out_im(o_im1), .out_valid(o_valid1), .out_first(o_first1), .overrun(ovr1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cmp(input string name, input exp_t e, input logic first, input int re, input int im);
    checks++;
    if (cyc != e.cyc || first != e.first || re != e.re || im != e.im) begin
      errors++;
      $display("FAIL %s actual cyc=%0d first=%0b re=%0d im=%0d required cyc=%0d first=%0b re=%0d im=%0d",
               name, cyc, first, re, im, e.cyc, e.first, e.re, e.im);
    end
  endtask

  // Called just after a rising edge; the pair is sampled on the next edge.
  task automatic issue(input int i, input bit expect_out);
    exp_t e;
    a_re = 16'(VT[i][0]); a_im = 16'(VT[i][1]);
    b_re = 16'(VT[i][2]); b_im = 16'(VT[i][3]);
    cos_d = 14'(VT[i][4]); sin_d = 14'(VT[i][5]);
    in_valid = 1'b1;
    if (expect_out) begin
      e = '{cyc + 5, 1'b1, VT[i][6],  VT[i][7]};  q0.push_back(e);
      e = '{cyc + 6, 1'b0, VT[i][8],  VT[i][9]};  q0.push_back(e);
      e = '{cyc + 5, 1'b1, VT[i][10], VT[i][11]}; q1.push_back(e);
      e = '{cyc + 6, 1'b0, VT[i][12], VT[i][13]}; q1.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_valid0) begin
        run0++;
        if (run0 > max_run0) max_run0 = run0;
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL out0_unexpected actual re=%0d im=%0d required no output", o_re0, o_im0);
        end else begin
          e = q0.pop_front();
          cmp("out0", e, o_first0, int'(o_re0), int'(o_im0));
        end
      end else run0 = 0;
      if (o_valid1) begin
        run1++;
        if (run1 > max_run1) max_run1 = run1;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL out1_unexpected actual re=%0d im=%0d required no output", o_re1, o_im1);
        end else begin
          e = q1.pop_front();
          cmp("out1", e, o_first1, int'(o_re1), int'(o_im1));
        end
      end else run1 = 0;
    end
  end

  initial begin
    #1;
    check("rst_out_valid", int'(o_valid0), 0);
    check("rst_out_first", int'(o_first0), 0);
    check("rst_overrun", int'(ovr0), 0);
    check("rst_out_re", int'(o_re0), 0);
    check("rst_out_im1", int'(o_im1), 0);
    #21 rst_n = 1'b1;
    idle(2);

    // Single pair: latency and identity twiddle
    issue(0, 1'b1);
    idle(8);

    // All vectors at spacing 2: must stream gap-free
    max_run0 = 0; max_run1 = 0;
    for (int i = 0; i < 7; i++) begin
      issue(i, 1'b1);
      idle(1);
    end
    idle(10);
    check("gapfree_run0", max_run0, 14);
    check("gapfree_run1", max_run1, 14);
    check("overrun_clear0", int'(ovr0), 0);

    // Back-to-back input: second dropped, third accepted
    issue(0, 1'b1);
    issue(3, 1'b0);
    issue(4, 1'b1);
    idle(10);
    check("overrun_set0", int'(ovr0), 1);
    check("overrun_set1", int'(ovr1), 1);
    issue(5, 1'b1);
    idle(8);
    check("overrun_sticky0", int'(ovr0), 1);

    // Reset with two pairs in flight
    issue(6, 1'b1);
    idle(1);
    issue(1, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_re0", int'(o_re0), 0);
    check("midrst_out_im0", int'(o_im0), 0);
    check("midrst_out_valid0", int'(o_valid0), 0);
    check("midrst_overrun0", int'(ovr0), 0);
    check("midrst_out_re1", int'(o_re1), 0);
    q0.delete();
    q1.delete();
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    idle(12);

    issue(2, 1'b1);
    idle(10);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
